mem_req_ctrl: RTL

//  Request front-end sitting directly upstream of the 1024x8 read/write memory.

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/mem_cmd_fifo.sv | 47 ++++
 rtl/mem_req_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory request front-end: default widths,
// read-sequencing FSM encoding and command word layout {we, addr, wdata}.
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_ISSUED = 2'd1,
        ST_RD_DATA   = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    // Command word: we in the MSB, then address, then write data in the LSBs.
    function automatic int cmd_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; head word is read combinationally.
// No bypass: a word pushed on an edge is visible at the head only after that edge.
module mem_cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             push_en;
    logic             pop_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop_en)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// In-order request front-end for the 1024x8 memory: command FIFO, read FSM, response
// registers. Optional MEM_REQ_CTRL_STATS_EN builds saturating read/write counters.
//
//  state        | meaning
//  -------------+-------------------------------------------------------------
//  ST_IDLE      | pop head each cycle; writes issue and stay, a read leaves
//  ST_RD_ISSUED | mem_rd_req pulse done; memory updates read data this edge
//  ST_RD_DATA   | capture mem_rd_data into the response registers
//  ST_RESP      | hold response until accepted; may pop next command on accept
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt
);

    localparam int CMD_W = cmd_width(ADDR_W, DATA_W);

    state_t            state;
    state_t            state_nxt;
    logic [CMD_W-1:0]  head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              resp_done;
    logic              pop;
    logic              wr_issue;
    logic              rd_issue;

    // Ready is held low during reset so every output reads 0 while rst is high.
    assign req_ready = !fifo_full && !rst;

    mem_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .wdata ({req_we, req_addr, req_wdata}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_we    = head[CMD_W-1];
    assign head_addr  = head[ADDR_W+DATA_W-1:DATA_W];
    assign head_wdata = head[DATA_W-1:0];
    assign resp_done  = (state == ST_RESP) && resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (rd_issue) state_nxt = ST_RD_ISSUED;
            ST_RD_ISSUED: state_nxt = ST_RD_DATA;
            ST_RD_DATA:   state_nxt = ST_RESP;
            ST_RESP: begin
                if (resp_done) state_nxt = rd_issue ? ST_RD_ISSUED : ST_IDLE;
            end
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Popping is allowed from IDLE, or on the response handshake edge.
    always_comb begin
        pop      = ((state == ST_IDLE) || resp_done) && !fifo_empty;
        wr_issue = pop && head_we;
        rd_issue = pop && !head_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_addr   <= '0;
        end else begin
            mem_wr_req <= wr_issue;
            mem_rd_req <= rd_issue;
            if (wr_issue) begin
                mem_wr_addr <= head_addr;
                mem_wr_data <= head_wdata;
            end
            if (rd_issue) mem_rd_addr <= head_addr;
            if (state == ST_RD_DATA) begin
                resp_valid <= 1'b1;
                resp_data  <= mem_rd_data;
                resp_addr  <= mem_rd_addr;
            end else if (resp_done) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef MEM_REQ_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
        end else begin
            if (resp_done && stat_rd_cnt != 16'hFFFF)
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            if (mem_wr_req && stat_wr_cnt != 16'hFFFF)
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
        end
    end
`else
    assign stat_rd_cnt = '0;
    assign stat_wr_cnt = '0;
`endif

endmodule
